// File: rtl/mrh_inst_buffer.sv
// Instruction buffer between the I-cache response path and dispatch: queues
// fetch lines and presents DISP_SIZE aligned instruction slots per cycle.
package mrh_pkg;
  typedef struct packed {
    logic         valid;
    logic [255:0] data;
    logic [31:0]  be;
  } ic_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
  } inst_buf_t;
endpackage

module mrh_inst_buffer #(
  parameter int DISP_SIZE = 4,
  parameter int DEPTH     = 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  input  mrh_pkg::ic_resp_t                    i_ic_resp,
  output logic                                 o_ic_ready,
  input  logic                                 i_flush,
  output mrh_pkg::inst_buf_t [DISP_SIZE-1:0]   o_inst_buf,
  input  logic                                 i_inst_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [3:0] DISP4 = 4'(DISP_SIZE);

  logic [255:0]         data_q [DEPTH];
  logic [255:0]         data_d [DEPTH];
  logic [7:0]           vld_q  [DEPTH];
  logic [7:0]           vld_d  [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2:0]           offset_q, offset_d;

  logic [7:0]           resp_vld;
  logic [255:0]         head_data;
  logic [7:0]           head_vld;
  logic [DISP_SIZE-1:0] slot_vld;
  logic                 not_empty;
  logic                 last_group;
  logic                 advance;
  logic                 push;
  logic                 pop;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int w = 0; w < 8; w++) begin
      resp_vld[w] = &i_ic_resp.be[4*w +: 4];
    end
  end

  assign head_data  = data_q[rd_ptr_q];
  assign head_vld   = vld_q[rd_ptr_q];
  assign not_empty  = (count_q != '0);
  assign o_ic_ready = (count_q != CW'(DEPTH));

  // Slots are a pure mux of the head entry; nothing here sees i_ic_resp.
  for (genvar k = 0; k < DISP_SIZE; k++) begin : g_slot
    logic [2:0] idx;
    assign idx                 = offset_q + 3'(k);
    assign slot_vld[k]         = not_empty && head_vld[idx];
    assign o_inst_buf[k].valid = slot_vld[k];
    assign o_inst_buf[k].inst  = head_data[{idx, 5'b0} +: 32];
  end

  // A group with no valid words skips forward without waiting for dispatch.
  assign advance    = not_empty && (i_inst_ready || (slot_vld == '0));
  assign last_group = (({1'b0, offset_q} + DISP4) == 4'd8);
  assign pop        = advance && last_group && !i_flush;
  assign push       = i_ic_resp.valid && o_ic_ready && !i_flush && (resp_vld != '0);

  always_comb begin
    data_d   = data_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    offset_d = offset_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      offset_d = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = i_ic_resp.data;
        vld_d[wr_ptr_q]  = resp_vld;
        wr_ptr_d         = inc_ptr(wr_ptr_q);
      end
      if (advance) begin
        if (last_group) begin
          offset_d = '0;
          rd_ptr_d = inc_ptr(rd_ptr_q);
        end else begin
          offset_d = offset_q + 3'(DISP_SIZE);
        end
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      offset_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      offset_q <= offset_d;
    end
  end

  // Line storage needs no reset: count gates every slot valid bit.
  always_ff @(posedge i_clk) begin
    data_q <= data_d;
    vld_q  <= vld_d;
  end

  a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(push && (count_q == CW'(DEPTH))));
  a_count_bound: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    count_q <= CW'(DEPTH));
  a_disp_divides: assert property (@(posedge i_clk) (8 % DISP_SIZE) == 0);

endmodule

// File: tb/tb_mrh_inst_buffer.sv
// Scoreboard bench for mrh_inst_buffer: a line-level model predicts the
// dispatched instruction groups, a negedge monitor checks every handshake.
module tb_mrh_inst_buffer;
  localparam int DISP  = 4;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [DISP-1:0]       vld;
    logic [DISP-1:0][31:0] inst;
  } group_t;

  logic                              clk;
  logic                              rst_n;
  mrh_pkg::ic_resp_t                 resp;
  logic                              ic_ready;
  logic                              flush;
  mrh_pkg::inst_buf_t [DISP-1:0]     inst_buf;
  logic                              inst_ready;

  group_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cycle = 0;
  bit     measuring = 0;
  int     hs_count = 0;
  int     first_hs = 0;
  int     last_hs = 0;

  mrh_inst_buffer #(.DISP_SIZE(DISP), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_ic_resp    (resp),
    .o_ic_ready   (ic_ready),
    .i_flush      (flush),
    .o_inst_buf   (inst_buf),
    .i_inst_ready (inst_ready)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  function automatic logic [DISP-1:0] cur_vld();
    logic [DISP-1:0] v;
    for (int k = 0; k < DISP; k++) v[k] = inst_buf[k].valid;
    return v;
  endfunction

  function automatic logic [255:0] seq_line(input logic [31:0] base);
    logic [255:0] d;
    for (int w = 0; w < 8; w++) d[32*w +: 32] = base + 32'(w);
    return d;
  endfunction

  // Reference: a line yields one dispatch group per aligned slice that holds
  // at least one fully enabled word; empty slices are never handed over.
  function automatic void model_push(input logic [255:0] d, input logic [31:0] be);
    logic [7:0] wv;
    group_t g;
    for (int w = 0; w < 8; w++) wv[w] = (be[4*w +: 4] == 4'hF);
    for (int s = 0; s < 8 / DISP; s++) begin
      g.vld = wv[s*DISP +: DISP];
      for (int k = 0; k < DISP; k++) g.inst[k] = d[32*(s*DISP + k) +: 32];
      if (g.vld != '0) exp_q.push_back(g);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Offers one line and waits (bounded) until the buffer accepts it.
  task automatic applyStimulus(input logic [255:0] d, input logic [31:0] be);
    int waited = 0;
    while (!ic_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!ic_ready) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL push_timeout got=ready0 expected=ready1");
      return;
    end
    resp = '{valid: 1'b1, data: d, be: be};
    model_push(d, be);
    step();
    resp.valid = 1'b0;
  endtask

  task automatic drainQueue(input string name);
    inst_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    step();
    step();
    inst_ready = 1'b0;
    checkOutput({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    checkOutput({name, "_drain_vld"}, 64'(cur_vld()), 64'd0);
  endtask

  always @(negedge clk) begin
    group_t e;
    logic [DISP-1:0] gv;
    bit ok;
    gv = cur_vld();
    if (rst_n && !flush && inst_ready && gv != '0) begin
      n_checks++;
      if (measuring) begin
        hs_count++;
        if (hs_count == 1) first_hs = cycle;
        last_hs = cycle;
      end
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("[TB] FAIL sb_unexpected got vld=%b inst0=%h expected no group", gv, inst_buf[0].inst);
      end else begin
        e = exp_q.pop_front();
        ok = (gv == e.vld);
        for (int k = 0; k < DISP; k++)
          if (e.vld[k] && inst_buf[k].inst !== e.inst[k]) ok = 0;
        if (!ok) begin
          n_errors++;
          $display("[TB] FAIL sb_group got vld=%b inst=%h %h %h %h expected vld=%b inst=%h %h %h %h",
                   gv, inst_buf[0].inst, inst_buf[1].inst, inst_buf[2].inst, inst_buf[3].inst,
                   e.vld, e.inst[0], e.inst[1], e.inst[2], e.inst[3]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] d;
    logic [31:0] be;
    int lines_left;
    int guard;

    rst_n = 0;
    flush = 0;
    inst_ready = 0;
    resp = '0;
    #12;
    checkOutput("reset_ready", 64'(ic_ready), 64'd1);
    checkOutput("reset_vld", 64'(cur_vld()), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    step();

    $display("[TB] test 1: single full line");
    inst_ready = 1;
    applyStimulus(seq_line(32'h13), 32'hFFFF_FFFF);
    checkOutput("t1_g0_vld", 64'(cur_vld()), 64'hF);
    checkOutput("t1_g0_inst0", 64'(inst_buf[0].inst), 64'h13);
    checkOutput("t1_g0_inst3", 64'(inst_buf[3].inst), 64'h16);
    step();
    checkOutput("t1_g1_inst0", 64'(inst_buf[0].inst), 64'h17);
    checkOutput("t1_g1_inst3", 64'(inst_buf[3].inst), 64'h1A);
    step();
    checkOutput("t1_empty_vld", 64'(cur_vld()), 64'd0);
    checkOutput("t1_empty_ready", 64'(ic_ready), 64'd1);

    $display("[TB] test 2: partial byte enables and auto-skip");
    inst_ready = 0;
    applyStimulus(seq_line(32'h100), 32'h0000_FFF0);
    checkOutput("t2_g0_vld", 64'(cur_vld()), 64'b1110);
    checkOutput("t2_g0_inst1", 64'(inst_buf[1].inst), 64'h101);
    inst_ready = 1;
    step();
    inst_ready = 0;
    checkOutput("t2_g1_vld", 64'(cur_vld()), 64'd0);
    step();
    checkOutput("t2_popped_ready", 64'(ic_ready), 64'd1);
    applyStimulus(seq_line(32'h200), 32'hFFFF_FFFF);
    checkOutput("t2_next_vld", 64'(cur_vld()), 64'hF);
    checkOutput("t2_next_inst0", 64'(inst_buf[0].inst), 64'h200);
    drainQueue("t2");

    $display("[TB] test 3: fill to depth and back-pressure");
    applyStimulus(seq_line(32'h300), 32'hFFFF_FFFF);
    applyStimulus(seq_line(32'h310), 32'hFFFF_FFFF);
    checkOutput("t3_full_ready", 64'(ic_ready), 64'd0);
    resp = '{valid: 1'b1, data: seq_line(32'h3F0), be: 32'hFFFF_FFFF};
    step();
    checkOutput("t3_reject_ready", 64'(ic_ready), 64'd0);
    step();
    resp.valid = 0;
    checkOutput("t3_hold_inst0", 64'(inst_buf[0].inst), 64'h300);
    checkOutput("t3_hold_vld", 64'(cur_vld()), 64'hF);
    inst_ready = 1;
    step();
    step();
    inst_ready = 0;
    checkOutput("t3_pop_ready", 64'(ic_ready), 64'd1);
    checkOutput("t3_line1_inst0", 64'(inst_buf[0].inst), 64'h310);
    drainQueue("t3");

    $display("[TB] test 4: flush with a simultaneous push");
    applyStimulus(seq_line(32'h400), 32'hFFFF_FFFF);
    applyStimulus(seq_line(32'h410), 32'hFFFF_FFFF);
    resp = '{valid: 1'b1, data: seq_line(32'h4F0), be: 32'hFFFF_FFFF};
    flush = 1;
    exp_q.delete();
    step();
    flush = 0;
    resp.valid = 0;
    checkOutput("t4_flush_vld", 64'(cur_vld()), 64'd0);
    checkOutput("t4_flush_ready", 64'(ic_ready), 64'd1);
    step();
    step();
    checkOutput("t4_flush_stays_empty", 64'(cur_vld()), 64'd0);

    $display("[TB] test 5: streaming 20 lines");
    hs_count = 0;
    measuring = 1;
    inst_ready = 1;
    for (int i = 0; i < 20; i++) applyStimulus(seq_line(32'h1000 + 32'(i) * 32'h10), 32'hFFFF_FFFF);
    drainQueue("t5");
    measuring = 0;
    checkOutput("t5_handshakes", 64'(hs_count), 64'd40);
    checkOutput("t5_span", 64'(last_hs - first_hs), 64'd39);

    $display("[TB] test 5b: random lines and dispatcher stalls");
    lines_left = 30;
    guard = 0;
    while (lines_left > 0 && guard < 2000) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
      case ($urandom_range(0, 3))
        0: be = 32'hFFFF_FFFF;
        1: be = 32'h0;
        2: be = $urandom;
        default: for (int w = 0; w < 8; w++) be[4*w +: 4] = ($urandom_range(0, 1) != 0) ? 4'hF : 4'h0;
      endcase
      if (ic_ready) begin
        resp = '{valid: 1'b1, data: d, be: be};
        model_push(d, be);
        lines_left--;
      end else begin
        resp = '{valid: ($urandom_range(0, 1) != 0), data: d, be: 32'hFFFF_FFFF};
      end
      step();
      guard++;
    end
    resp.valid = 0;
    checkOutput("t5b_lines_sent", 64'(lines_left), 64'd0);
    drainQueue("t5b");

    $display("[TB] test 6: asynchronous reset mid-stream");
    inst_ready = 0;
    applyStimulus(seq_line(32'h500), 32'hFFFF_FFFF);
    inst_ready = 1;
    step();
    inst_ready = 0;
    checkOutput("t6_pre_inst0", 64'(inst_buf[0].inst), 64'h504);
    #2;
    rst_n = 0;
    #1;
    exp_q.delete();
    checkOutput("t6_rst_vld", 64'(cur_vld()), 64'd0);
    checkOutput("t6_rst_ready", 64'(ic_ready), 64'd1);
    step();
    rst_n = 1;
    step();
    inst_ready = 1;
    applyStimulus(seq_line(32'h600), 32'hFFFF_FFFF);
    checkOutput("t6_restart_inst0", 64'(inst_buf[0].inst), 64'h600);
    checkOutput("t6_restart_vld", 64'(cur_vld()), 64'hF);
    drainQueue("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
